uart_input_loader: RTL and testbench
====================================

UART_INPUT_LOADER -- requirements
Module: uart_input_loader

Interface
REQ-001 The block SHALL have parameter NUM_INPUTS, default 10, giving the width of the redstone input vector.
REQ-002 The block SHALL have parameter CMD_SET_INPUTS, default 8'h02, giving the command byte that opens an input-load frame.
REQ-003 The block SHALL have parameter ACK_BYTE, default 8'h06, giving the byte returned after a completed frame.
REQ-004 The block SHALL have parameter TIMEOUT_CYCLES, default 1000000, giving the maximum idle gap between frame bytes, in i_clk cycles.
REQ-005 The block SHALL derive the local constant NUM_BYTES = ceil(NUM_INPUTS/8).
REQ-006 i_clk  input  1  single clock; all state changes on its rising edge.
REQ-007 i_rst  input  1  asynchronous, active-low reset.
REQ-008 i_rx_valid  input  1  one-cycle strobe marking a received byte.
REQ-009 i_rx_data  input  8  received byte, valid while i_rx_valid=1.
REQ-010 i_tx_ready  input  1  transmitter idle and able to accept a byte.
REQ-011 o_tx_start  output  1  one-cycle request to transmit o_tx_data.
REQ-012 o_tx_data  output  8  byte to transmit.
REQ-013 o_inputs  output  NUM_INPUTS  registered input vector driven to the redstone core.
REQ-014 o_update  output  1  one-cycle pulse, coincident with the first cycle the new o_inputs value is visible.
REQ-015 o_busy  output  1  high in every state except IDLE.
REQ-016 o_error  output  1  one-cycle pulse on frame timeout.

Function
REQ-017 The FSM SHALL have exactly four states: IDLE, RECV, APPLY and ACK.
REQ-018 IDLE: a strobe with i_rx_data==CMD_SET_INPUTS SHALL clear the byte counter and the timeout counter and go to RECV; every other byte SHALL be ignored.
REQ-019 RECV: the k-th data strobe (k=0..NUM_BYTES-1) SHALL write i_rx_data into shadow bits [8k+7:8k], LSB byte first.
REQ-020 RECV: shadow bits at or above NUM_INPUTS SHALL be discarded.
REQ-021 RECV: the strobe carrying byte NUM_BYTES-1 SHALL move the FSM to APPLY.
REQ-022 RECV: a byte equal to CMD_SET_INPUTS SHALL be treated as data, not as a restart.
REQ-023 RECV: the timeout counter SHALL clear on each strobe and increment on every other cycle.
REQ-024 RECV: when the timeout counter reaches TIMEOUT_CYCLES-1 without a strobe, the block SHALL pulse o_error for one cycle, discard the shadow and return to IDLE; o_inputs SHALL be unchanged.
REQ-025 APPLY (one cycle): o_inputs SHALL load the shadow, o_update SHALL pulse, and the FSM SHALL go to ACK; latency from the final data strobe to the new o_inputs value is 1 cycle.
REQ-026 ACK: o_tx_data SHALL equal ACK_BYTE.
REQ-027 ACK: in the first cycle with i_tx_ready=1, o_tx_start SHALL be 1 for exactly that cycle and the FSM SHALL return to IDLE next cycle.
REQ-028 ACK: while i_tx_ready=0 the FSM SHALL wait without a timeout.
REQ-029 APPLY and ACK: received strobes SHALL be ignored.
REQ-030 o_inputs SHALL change only in APPLY; frames are atomic and partial frames are never visible.
REQ-031 A strobe coincident with the timeout terminal cycle SHALL count as a byte, and the timeout SHALL NOT fire.
REQ-032 The byte and timeout counters SHALL be sized to hold NUM_BYTES and TIMEOUT_CYCLES without wrap.

Reset
REQ-033 While i_rst=0, regardless of clock, the block SHALL force: state=IDLE, o_inputs=0, o_tx_start=0, o_tx_data=0, o_update=0, o_busy=0, o_error=0, and shadow and counters to 0.
REQ-034 Reset asserted mid-frame SHALL abandon the frame and produce no ACK.
REQ-035 After deassertion, the first strobe SHALL be decoded as in IDLE.

Verification
REQ-036 Load: NUM_INPUTS=10, i_tx_ready=1, bytes 02,A5,03 -> o_inputs=10'h3A5 one cycle after the 03 strobe, o_update pulse, then one o_tx_start with o_tx_data=06.
REQ-037 Truncation: bytes 02,FF,FF -> o_inputs=10'h3FF, upper 6 bits of byte 2 dropped.
REQ-038 Timeout: TIMEOUT_CYCLES=100, bytes 02,5A, then silence -> o_error pulse 100 cycles after the 5A strobe; o_inputs keeps its prior value; the next 02 starts a fresh frame.
REQ-039 Filtering: bytes 01,7F,02,11,22 -> 01 and 7F ignored; o_inputs=10'h211.
REQ-040 ACK back-pressure: i_tx_ready held at 0 for 50 cycles after APPLY -> o_busy stays 1, no o_tx_start; i_tx_ready rises -> exactly one o_tx_start.
REQ-041 Reset mid-frame: i_rst pulsed low after 02,33 -> o_inputs=0 and no ACK; a subsequent full frame loads correctly.

Source files
------------

// File: rtl/uart_input_loader.sv
// -----------------------------------------------------------------------------
// uart_input_loader
//
// Receives a framed input-vector update from a byte-wide UART receiver and
// loads it atomically into the registered redstone input vector, then
// returns an acknowledge byte through the UART transmitter.
//
// Frame: CMD_SET_INPUTS followed by NUM_BYTES data bytes, LSB byte first.
// A frame that stalls for TIMEOUT_CYCLES is abandoned with an error pulse.
//
// Ports
//   i_clk       single clock, rising edge
//   i_rst       asynchronous active-low reset
//   i_rx_valid  one-cycle strobe for a received byte
//   i_rx_data   received byte
//   i_tx_ready  transmitter idle
//   o_tx_start  one-cycle transmit request
//   o_tx_data   byte to transmit (ACK_BYTE while acknowledging, else 0)
//   o_inputs    registered input vector
//   o_update    pulse in the first cycle a new o_inputs value is visible
//   o_busy      high whenever a frame is in progress or being acknowledged
//   o_error     one-cycle pulse when a frame times out
//
// state | meaning
// IDLE  | waiting for the command byte, other bytes ignored
// RECV  | collecting data bytes into the shadow, timeout running
// APPLY | new vector visible on o_inputs, o_update high
// ACK   | offering ACK_BYTE until the transmitter accepts it
// -----------------------------------------------------------------------------
module uart_input_loader #(
    parameter int          NUM_INPUTS     = 10,
    parameter logic [7:0]  CMD_SET_INPUTS = 8'h02,
    parameter logic [7:0]  ACK_BYTE       = 8'h06,
    parameter int          TIMEOUT_CYCLES = 1000000
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_rx_valid,
    input  logic [7:0]            i_rx_data,
    input  logic                  i_tx_ready,
    output logic                  o_tx_start,
    output logic [7:0]            o_tx_data,
    output logic [NUM_INPUTS-1:0] o_inputs,
    output logic                  o_update,
    output logic                  o_busy,
    output logic                  o_error
);

    localparam int NUM_BYTES = (NUM_INPUTS + 7) / 8;
    localparam int BCNT_W    = (NUM_BYTES > 1) ? $clog2(NUM_BYTES + 1) : 1;
    localparam int TCNT_W    = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        APPLY = 2'd2,
        ACK   = 2'd3
    } state_t;

    state_t                  state, state_next;
    logic [BCNT_W-1:0]       byte_cnt;
    logic [TCNT_W-1:0]       tmo_cnt;
    logic [NUM_INPUTS-1:0]   shadow;
    logic [NUM_INPUTS-1:0]   shadow_next;
    logic                    cmd_seen;
    logic                    last_byte;
    logic                    timeout_hit;

    assign cmd_seen    = i_rx_valid && (i_rx_data == CMD_SET_INPUTS);
    assign last_byte   = (byte_cnt == BCNT_W'(NUM_BYTES - 1));
    // A strobe in the terminal cycle wins over the timeout.
    assign timeout_hit = (state == RECV) && !i_rx_valid &&
                         (tmo_cnt == TCNT_W'(TIMEOUT_CYCLES - 1));

    // Merge the incoming byte into its slot; bits beyond NUM_INPUTS have no
    // home in the shadow and simply fall away.
    always_comb begin
        shadow_next = shadow;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (BCNT_W'(i / 8) == byte_cnt) begin
                shadow_next[i] = i_rx_data[i % 8];
            end
        end
    end

    // State register
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (cmd_seen) begin
                    state_next = RECV;
                end
            end
            RECV: begin
                if (i_rx_valid && last_byte) begin
                    state_next = APPLY;
                end else if (timeout_hit) begin
                    state_next = IDLE;
                end
            end
            APPLY: begin
                state_next = ACK;
            end
            ACK: begin
                if (i_tx_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Output logic
    always_comb begin
        o_busy     = (state != IDLE);
        o_update   = (state == APPLY);
        o_tx_start = (state == ACK) && i_tx_ready;
        o_tx_data  = (state == ACK) ? ACK_BYTE : 8'h00;
    end

    // Datapath: counters, shadow, output vector, error pulse
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            byte_cnt <= '0;
            tmo_cnt  <= '0;
            shadow   <= '0;
            o_inputs <= '0;
            o_error  <= 1'b0;
        end else begin
            o_error <= timeout_hit;
            case (state)
                IDLE: begin
                    if (cmd_seen) begin
                        byte_cnt <= '0;
                        tmo_cnt  <= '0;
                        shadow   <= '0;
                    end
                end
                RECV: begin
                    if (i_rx_valid) begin
                        tmo_cnt <= '0;
                        if (last_byte) begin
                            // Captured on the edge into APPLY so the new
                            // vector and o_update share the APPLY cycle.
                            o_inputs <= shadow_next;
                            shadow   <= '0;
                            byte_cnt <= '0;
                        end else begin
                            shadow   <= shadow_next;
                            byte_cnt <= byte_cnt + BCNT_W'(1);
                        end
                    end else if (timeout_hit) begin
                        shadow   <= '0;
                        byte_cnt <= '0;
                        tmo_cnt  <= '0;
                    end else begin
                        tmo_cnt <= tmo_cnt + TCNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_input_loader.sv
module tb_uart_input_loader;

    localparam int T_OUT = 100;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b0;
    logic       i_rx_valid = 1'b0;
    logic [7:0] i_rx_data = 8'h00;
    logic       i_tx_ready = 1'b1;
    logic       o_tx_start;
    logic [7:0] o_tx_data;
    logic [9:0] o_inputs;
    logic       o_update;
    logic       o_busy;
    logic       o_error;

    int n_err = 0;
    int n_chk = 0;

    uart_input_loader #(
        .NUM_INPUTS     (10),
        .CMD_SET_INPUTS (8'h02),
        .ACK_BYTE       (8'h06),
        .TIMEOUT_CYCLES (T_OUT)
    ) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_rx_valid (i_rx_valid),
        .i_rx_data  (i_rx_data),
        .i_tx_ready (i_tx_ready),
        .o_tx_start (o_tx_start),
        .o_tx_data  (o_tx_data),
        .o_inputs   (o_inputs),
        .o_update   (o_update),
        .o_busy     (o_busy),
        .o_error    (o_error)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        int         n;
        logic [7:0] b [5];
        logic [9:0] exp;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // one clock edge, then land on the following falling edge
    task automatic tick();
        @(posedge i_clk);
        @(negedge i_clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        i_rx_valid = 1'b1;
        i_rx_data  = b;
        tick();
        i_rx_valid = 1'b0;
        i_rx_data  = 8'h00;
    endtask

    task automatic set_vec(input int idx, input int n, input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input logic [7:0] b3, input logic [7:0] b4,
                           input logic [9:0] exp);
        vecs[idx].n    = n;
        vecs[idx].b[0] = b0;
        vecs[idx].b[1] = b1;
        vecs[idx].b[2] = b2;
        vecs[idx].b[3] = b3;
        vecs[idx].b[4] = b4;
        vecs[idx].exp  = exp;
    endtask

    // behavioural reference state for the random phase
    bit         m_col, m_upd, m_ack, m_err;
    int         m_sil;
    logic [7:0] m_frame [$];
    logic [9:0] m_in;

    initial begin
        int k;
        int quiet_left;
        bit v, r;
        logic [7:0] d;

        set_vec(0, 3, 8'h02, 8'hA5, 8'h03, 8'h00, 8'h00, 10'h3A5);
        set_vec(1, 3, 8'h02, 8'hFF, 8'hFF, 8'h00, 8'h00, 10'h3FF);
        set_vec(2, 5, 8'h01, 8'h7F, 8'h02, 8'h11, 8'h22, 10'h211);
        set_vec(3, 3, 8'h02, 8'h02, 8'h02, 8'h00, 8'h00, 10'h202);
        set_vec(4, 3, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 10'h000);
        set_vec(5, 3, 8'h02, 8'h3C, 8'hC1, 8'h00, 8'h00, 10'h13C);

        // reset state, before any clock edge
        #1;
        chk("rst_inputs", 32'(o_inputs), 0);
        chk("rst_busy", 32'(o_busy), 0);
        chk("rst_txstart", 32'(o_tx_start), 0);
        chk("rst_txdata", 32'(o_tx_data), 0);
        chk("rst_update", 32'(o_update), 0);
        chk("rst_error", 32'(o_error), 0);
        @(negedge i_clk);
        tick();
        i_rst = 1'b1;
        tick();

        // table-driven frames, transmitter always ready
        for (int i = 0; i < 6; i++) begin
            for (int j = 0; j < vecs[i].n; j++) send_byte(vecs[i].b[j]);
            chk($sformatf("v%0d_update", i), 32'(o_update), 1);
            chk($sformatf("v%0d_inputs", i), 32'(o_inputs), 32'(vecs[i].exp));
            chk($sformatf("v%0d_busy_apply", i), 32'(o_busy), 1);
            chk($sformatf("v%0d_nostart_apply", i), 32'(o_tx_start), 0);
            tick();
            chk($sformatf("v%0d_txstart", i), 32'(o_tx_start), 1);
            chk($sformatf("v%0d_txdata", i), 32'(o_tx_data), 32'h06);
            chk($sformatf("v%0d_update_once", i), 32'(o_update), 0);
            tick();
            chk($sformatf("v%0d_idle", i), 32'(o_busy), 0);
            chk($sformatf("v%0d_txstart_once", i), 32'(o_tx_start), 0);
            chk($sformatf("v%0d_hold", i), 32'(o_inputs), 32'(vecs[i].exp));
        end

        // timeout: o_inputs currently 13C
        send_byte(8'h02);
        send_byte(8'h5A);
        k = 0;
        while (k < 150 && o_error !== 1'b1) begin
            tick();
            k++;
        end
        chk("tmo_delay", 32'(k), 32'(T_OUT));
        chk("tmo_inputs_kept", 32'(o_inputs), 32'h13C);
        chk("tmo_idle", 32'(o_busy), 0);
        tick();
        chk("tmo_pulse_once", 32'(o_error), 0);
        send_byte(8'h02);
        send_byte(8'h44);
        send_byte(8'h01);
        chk("tmo_fresh_update", 32'(o_update), 1);
        chk("tmo_fresh_inputs", 32'(o_inputs), 32'h144);
        tick();
        tick();

        // strobe exactly on the timeout terminal cycle counts as data
        send_byte(8'h02);
        send_byte(8'h11);
        for (int i = 0; i < T_OUT - 1; i++) tick();
        chk("term_no_error", 32'(o_error), 0);
        chk("term_busy", 32'(o_busy), 1);
        send_byte(8'h02);
        chk("term_update", 32'(o_update), 1);
        chk("term_inputs", 32'(o_inputs), 32'h211);
        chk("term_error", 32'(o_error), 0);
        tick();
        tick();

        // acknowledge back-pressure, with strobes during APPLY and ACK ignored
        i_tx_ready = 1'b0;
        send_byte(8'h02);
        send_byte(8'h0F);
        i_rx_valid = 1'b1;
        i_rx_data  = 8'h02;
        tick();
        chk("bp_inputs", 32'(o_inputs), 32'h20F);
        chk("bp_update", 32'(o_update), 1);
        for (int i = 0; i < 50; i++) begin
            tick();
            i_rx_valid = (i == 10);
            i_rx_data  = 8'h02;
            #1;
            chk("bp_busy", 32'(o_busy), 1);
            chk("bp_nostart", 32'(o_tx_start), 0);
            @(negedge i_clk);
        end
        i_rx_valid = 1'b0;
        i_tx_ready = 1'b1;
        #1;
        chk("bp_start", 32'(o_tx_start), 1);
        chk("bp_txdata", 32'(o_tx_data), 32'h06);
        @(negedge i_clk);
        tick();
        chk("bp_idle", 32'(o_busy), 0);
        chk("bp_start_once", 32'(o_tx_start), 0);
        chk("bp_inputs_kept", 32'(o_inputs), 32'h20F);

        // reset mid-frame
        send_byte(8'h02);
        send_byte(8'h33);
        i_rst = 1'b0;
        #1;
        chk("mrst_inputs", 32'(o_inputs), 0);
        chk("mrst_busy", 32'(o_busy), 0);
        @(negedge i_clk);
        tick();
        i_rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("mrst_no_ack", 32'(o_tx_start), 0);
        end
        send_byte(8'h33);
        chk("mrst_first_idle", 32'(o_busy), 0);
        send_byte(8'h02);
        send_byte(8'hA5);
        send_byte(8'h03);
        chk("mrst_reload", 32'(o_inputs), 32'h3A5);
        tick();
        chk("mrst_ack", 32'(o_tx_start), 1);
        tick();

        // randomized traffic against the reference model, from a clean reset
        i_rst = 1'b0;
        tick();
        i_rst = 1'b1;
        m_col = 0; m_upd = 0; m_ack = 0; m_err = 0; m_sil = 0; m_in = '0;
        m_frame.delete();
        quiet_left = 0;
        for (int c = 0; c < 4000; c++) begin
            if (quiet_left > 0) begin
                quiet_left--;
                v = 1'b0;
            end else begin
                if ($urandom_range(0, 299) == 0) quiet_left = $urandom_range(95, 110);
                v = ($urandom_range(0, 2) == 0);
            end
            d = ($urandom_range(0, 3) == 0) ? 8'h02 : 8'($urandom_range(0, 255));
            r = 1'($urandom_range(0, 1));
            i_rx_valid = v;
            i_rx_data  = d;
            i_tx_ready = r;
            #1;
            chk("rnd_busy", 32'(o_busy), 32'(m_col | m_upd | m_ack));
            chk("rnd_update", 32'(o_update), 32'(m_upd));
            chk("rnd_txstart", 32'(o_tx_start), 32'(m_ack & r));
            chk("rnd_txdata", 32'(o_tx_data), m_ack ? 32'h06 : 32'h00);
            chk("rnd_error", 32'(o_error), 32'(m_err));
            chk("rnd_inputs", 32'(o_inputs), 32'(m_in));

            m_err = 0;
            if (m_upd) begin
                m_upd = 0;
                m_ack = 1;
            end else if (m_ack) begin
                if (r) m_ack = 0;
            end else if (m_col) begin
                if (v) begin
                    m_frame.push_back(d);
                    m_sil = 0;
                    if (m_frame.size() == 2) begin
                        m_in = {m_frame[1][1:0], m_frame[0]};
                        m_frame.delete();
                        m_col = 0;
                        m_upd = 1;
                    end
                end else begin
                    m_sil++;
                    if (m_sil == T_OUT) begin
                        m_err = 1;
                        m_col = 0;
                        m_frame.delete();
                    end
                end
            end else if (v && d == 8'h02) begin
                m_col = 1;
                m_sil = 0;
                m_frame.delete();
            end
            @(negedge i_clk);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
